// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller:
// opcodes, FSM states and the decoder control-word layout.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI7 = 6'h07;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // Opcodes that read rt as a source; others (lw, addi-type) only read rs.
    function automatic logic reads_rt(input logic [5:0] opcode);
        reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter used for stall/flush statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and branch/jump flush control for the ID stage.
// Drives the decoder bubble enable, PC/IF-ID write gates and flushes.
module hazard_ctrl_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int BRANCH_PENALTY  = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_jump,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] STALL_REM = 2'(LOAD_USE_STALLS - 1);
    localparam logic [1:0] FLUSH_REM = 2'(BRANCH_PENALTY - 1);

    state_t     state, next_state;
    logic [1:0] remain, next_remain;
    logic       hit;
    logic       stalling;

    assign hit = ex_MemRead && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) ||
                  ((ex_rt == id_rt) && reads_rt(id_opcode)));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control     = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stalling    = 1'b0;
        next_state  = state;
        next_remain = remain;
        // Outputs are forced to their idle values while reset is held.
        if (rst_n) begin
            if (state == ST_FLUSH) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                control     = 1'b0;
                next_remain = remain - 2'd1;
                if (remain <= 2'd1) begin
                    next_state = ST_RUN;
                end
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                control     = 1'b0;
                if (BRANCH_PENALTY > 1) begin
                    next_state  = ST_FLUSH;
                    next_remain = FLUSH_REM;
                end else begin
                    next_state  = ST_RUN;
                    next_remain = 2'd0;
                end
            end else if (state == ST_STALL) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                control     = 1'b0;
                stalling    = 1'b1;
                next_remain = remain - 2'd1;
                if (remain <= 2'd1) begin
                    next_state = ST_RUN;
                end
            end else if (hit) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                control     = 1'b0;
                stalling    = 1'b1;
                if (LOAD_USE_STALLS > 1) begin
                    next_state  = ST_STALL;
                    next_remain = STALL_REM;
                end
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            remain <= 2'd0;
        end else begin
            state  <= next_state;
            remain <= next_remain;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stalling),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush | id_ex_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1/1/16 and 3/2/3) on shared
// inputs, checked against a cycle model through an expectation queue.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_jump, ex_MemRead, ex_branch_taken;

    logic        pw0, iw0, c0, iff0, ief0;
    logic [15:0] sc0, fc0;
    logic        pw1, iw1, c1, iff1, ief1;
    logic [2:0]  sc1, fc1;

    hazard_ctrl_unit #(.LOAD_USE_STALLS(1), .BRANCH_PENALTY(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_jump(id_jump), .ex_MemRead(ex_MemRead),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(pw0), .if_id_write(iw0), .control(c0),
        .if_id_flush(iff0), .id_ex_flush(ief0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl_unit #(.LOAD_USE_STALLS(3), .BRANCH_PENALTY(2), .CNT_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_jump(id_jump), .ex_MemRead(ex_MemRead),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(pw1), .if_id_write(iw1), .control(c1),
        .if_id_flush(iff1), .id_ex_flush(ief1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    typedef struct {
        string      tag;
        int         inst;
        logic [4:0] outs;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam int LUS  [2] = '{1, 3};
    localparam int BP   [2] = '{1, 2};
    localparam int CMAX [2] = '{65535, 7};

    // Model state: 0 run, 1 stall, 2 flush
    int   m_st[2], m_left[2], m_sc[2], m_fc[2];
    int   n_st[2], n_left[2];
    logic inc_s[2], inc_f[2];

    task automatic model_eval(input int i, output exp_t e);
        logic       hz;
        logic [4:0] o;
        int         ns, nl;
        hz = ex_MemRead && (ex_rt != 0) &&
             ((ex_rt == id_rs) ||
              ((ex_rt == id_rt) &&
               (id_opcode == 6'h00 || id_opcode == 6'h2B || id_opcode == 6'h04)));
        ns = m_st[i];
        nl = m_left[i];
        if (!rst_n) begin
            o = 5'b11100; ns = 0; nl = 0;
            m_sc[i] = 0; m_fc[i] = 0;
        end else if (m_st[i] == 2) begin
            o = 5'b11011; nl = m_left[i] - 1;
            if (m_left[i] == 1) ns = 0;
        end else if (ex_branch_taken) begin
            o = 5'b11011;
            if (BP[i] > 1) begin ns = 2; nl = BP[i] - 1; end
            else begin ns = 0; nl = 0; end
        end else if (m_st[i] == 1) begin
            o = 5'b00000; nl = m_left[i] - 1;
            if (m_left[i] == 1) ns = 0;
        end else if (hz) begin
            o = 5'b00000;
            if (LUS[i] > 1) begin ns = 1; nl = LUS[i] - 1; end
        end else if (id_jump) begin
            o = 5'b11110;
        end else begin
            o = 5'b11100;
        end
        e.inst = i;
        e.outs = o;
        e.sc = m_sc[i];
        e.fc = m_fc[i];
        n_st[i] = ns;
        n_left[i] = nl;
        inc_s[i] = rst_n && (o == 5'b00000);
        inc_f[i] = rst_n && (o[1] || o[0]);
    endtask

    task automatic model_commit(input int i);
        m_st[i] = n_st[i];
        m_left[i] = n_left[i];
        if (!rst_n) begin
            m_sc[i] = 0; m_fc[i] = 0;
        end else begin
            if (inc_s[i] && m_sc[i] < CMAX[i]) m_sc[i]++;
            if (inc_f[i] && m_fc[i] < CMAX[i]) m_fc[i]++;
        end
    endtask

    task automatic check(input string tag, input string what, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s %s: got %0d expected %0d", tag, what, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic mr,
                        input logic [4:0] ert, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic jmp, input logic br);
        exp_t e;
        logic [4:0] got;
        int gsc, gfc;
        @(posedge clk);
        #1;
        rst_n = r; ex_MemRead = mr; ex_rt = ert; id_opcode = op;
        id_rs = rs; id_rt = rt; id_jump = jmp; ex_branch_taken = br;
        for (int i = 0; i < 2; i++) begin
            model_eval(i, e);
            e.tag = tag;
            q.push_back(e);
        end
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.inst == 0) begin
                got = {pw0, iw0, c0, iff0, ief0};
                gsc = int'(sc0); gfc = int'(fc0);
            end else begin
                got = {pw1, iw1, c1, iff1, ief1};
                gsc = int'(sc1); gfc = int'(fc1);
            end
            n_cmp++;
            assert (got === e.outs) else begin
                n_err++;
                $error("FAIL %s u%0d outs{pw,iw,ctl,iff,ief}: got %b expected %b",
                       e.tag, e.inst, got, e.outs);
            end
            check(e.tag, $sformatf("u%0d stall_cnt", e.inst), gsc, e.sc);
            check(e.tag, $sformatf("u%0d flush_cnt", e.inst), gfc, e.fc);
        end
        for (int i = 0; i < 2; i++) model_commit(i);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lu_hit(input string tag);
        step(tag, 1'b1, 1'b1, 5'd8, OP_RTYPE, 5'd8, 5'd9, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        rst_n = 1'b0; ex_MemRead = 1'b0; ex_rt = '0; id_opcode = '0;
        id_rs = '0; id_rt = '0; id_jump = 1'b0; ex_branch_taken = 1'b0;

        // reset state, including with a hazard present on the inputs
        step("reset_idle", 1'b0, 1'b0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b0);
        step("reset_hz", 1'b0, 1'b1, 5'd8, OP_RTYPE, 5'd8, 5'd9, 1'b0, 1'b1);
        idle("run_idle");

        // lw $t0 then add using $t0 as rs
        lu_hit("lu_add_rs");
        idle("lu_after1");
        idle("lu_after2");
        idle("lu_after3");
        check("lu_totals", "u0 stall_cnt", int'(sc0), 1);
        check("lu_totals", "u1 stall_cnt", int'(sc1), 3);

        // no-hazard cases
        step("ex_rt_zero", 1'b1, 1'b1, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b0);
        step("no_memread", 1'b1, 1'b0, 5'd8, OP_RTYPE, 5'd8, 5'd8, 1'b0, 1'b0);
        step("lw_rt_only", 1'b1, 1'b1, 5'd8, OP_LW, 5'd3, 5'd8, 1'b0, 1'b0);
        step("addi7_rt", 1'b1, 1'b1, 5'd8, OP_ADDI7, 5'd3, 5'd8, 1'b0, 1'b0);

        // rt-source forms do stall
        step("sw_rt_hit", 1'b1, 1'b1, 5'd12, OP_SW, 5'd3, 5'd12, 1'b0, 1'b0);
        idle("sw_after1");
        idle("sw_after2");
        step("beq_rt_hit", 1'b1, 1'b1, 5'd5, OP_BEQ, 5'd1, 5'd5, 1'b0, 1'b0);
        idle("beq_after1");
        idle("beq_after2");

        // branch beats load-use in the same cycle; second branch in FLUSH ignored
        step("br_and_lu", 1'b1, 1'b1, 5'd8, OP_RTYPE, 5'd8, 5'd9, 1'b0, 1'b1);
        step("br_again", 1'b1, 1'b0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b1);
        idle("br_after");

        // jump alone, and jump losing to a load-use hit
        step("jump", 1'b1, 1'b0, 5'd0, OP_J, 5'd0, 5'd0, 1'b1, 1'b0);
        idle("jump_after");
        step("jump_vs_lu", 1'b1, 1'b1, 5'd8, OP_RTYPE, 5'd8, 5'd9, 1'b1, 1'b0);
        idle("jvl_after1");
        idle("jvl_after2");

        // branch pre-empts an ongoing stall
        lu_hit("pre_lu");
        step("pre_br", 1'b1, 1'b0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b1);
        idle("pre_after1");
        idle("pre_after2");

        // reset in the second stall cycle
        lu_hit("rst_lu");
        idle("rst_stall2");
        step("rst_mid", 1'b0, 1'b1, 5'd8, OP_RTYPE, 5'd8, 5'd9, 1'b0, 1'b0);
        idle("rst_rel1");
        idle("rst_rel2");
        check("rst_totals", "u1 stall_cnt", int'(sc1), 0);

        // drive u1's 3-bit counters into saturation
        for (int k = 0; k < 4; k++) begin
            lu_hit($sformatf("sat_lu%0d", k));
            idle($sformatf("sat_a%0d", k));
            idle($sformatf("sat_b%0d", k));
            step($sformatf("sat_br%0d", k), 1'b1, 1'b0, 5'd0, OP_RTYPE,
                 5'd0, 5'd0, 1'b0, 1'b1);
            idle($sformatf("sat_c%0d", k));
        end
        check("sat_final", "u1 stall_cnt", int'(sc1), 7);
        check("sat_final", "u1 flush_cnt", int'(fc1), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
